// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor_ctrl (with helper cell ssc_half_sub)
//  Purpose  : Bit-serial unsigned N-bit subtractor controller. Captures the
//             operands on a start handshake, feeds one bit pair per cycle
//             (LSB first) through a full subtractor made of two half
//             subtractors plus a borrow flip-flop, then presents a registered
//             difference, final borrow and zero flag with a one-cycle done.
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  Half-subtractor cell: o_d = x - y (one bit), o_b = borrow out.
// ----------------------------------------------------------------------------
module ssc_half_sub (
  input  logic i_x,
  input  logic i_y,
  output logic o_d,
  output logic o_b
);

  assign o_d = i_x ^ i_y;
  assign o_b = ~i_x & i_y;

endmodule

// ----------------------------------------------------------------------------
//  Top-level controller.
// ----------------------------------------------------------------------------
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  // Counter only needs to reach WIDTH-1; the increment past the last bit
  // wraps harmlessly because the FSM has already left RUN by then.
  localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  // Datapath registers
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;

  // Registered result outputs
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  // FSM decode
  logic             w_load;
  logic             w_step;
  logic             w_last;

  // Single-bit subtract stage
  logic             w_d1;
  logic             w_b1;
  logic             w_d;
  logic             w_b2;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_nxt;

  // --------------------------------------------------------------------------
  //  Full subtractor: first cell subtracts the operand bits, second cell
  //  subtracts the incoming borrow. At most one of the two cells can borrow,
  //  so OR-ing them gives the stage borrow out.
  // --------------------------------------------------------------------------
  ssc_half_sub u_hs_ops (
    .i_x (r_a_sh[0]),
    .i_y (r_b_sh[0]),
    .o_d (w_d1),
    .o_b (w_b1)
  );

  ssc_half_sub u_hs_borrow (
    .i_x (w_d1),
    .i_y (r_borrow),
    .o_d (w_d),
    .o_b (w_b2)
  );

  assign w_bout = w_b1 | w_b2;

  // New difference bit enters at the MSB; after WIDTH shifts bit 0 lands
  // in position 0 and the register holds the complete result.
  assign w_res_nxt = {w_d, r_res_sh[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (r_cnt == C_LAST_BIT) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting, borrow FF and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_res_sh <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_nxt;
      r_borrow <= w_bout;
      r_cnt    <= r_cnt + C_CNT_ONE;
    end
  end

  // Result outputs update only on the edge that completes the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b0;
    end else if (w_last) begin
      r_diff       <= w_res_nxt;
      r_borrow_out <= w_bout;
      r_zero       <= (w_res_nxt == '0);
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero       = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor_ctrl
//  Purpose  : Self-checking bench for serial_subtractor_ctrl at WIDTH=8 and
//             WIDTH=13. Directed scenarios plus randomized traffic compared
//             against a plain-arithmetic timeline model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start13 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [12:0] a13 = '0, b13 = '0;

  logic        busy8, done8, bor8, zero8;
  logic [7:0]  diff8;
  logic        busy13, done13, bor13, zero13;
  logic [12:0] diff13;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (bor8),
    .zero       (zero8)
  );

  serial_subtractor_ctrl #(.WIDTH(13)) u_dut13 (
    .clk        (clk),
    .rst        (rst),
    .start      (start13),
    .a          (a13),
    .b          (b13),
    .busy       (busy13),
    .done       (done13),
    .diff       (diff13),
    .borrow_out (bor13),
    .zero       (zero13)
  );

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the 8-bit DUT to be idle, then pulse start one cycle.
  task automatic start_op8(input logic [7:0] av, input logic [7:0] bv);
    int k;
    k = 0;
    while (busy8 && k < 50) begin
      tick();
      k++;
    end
    a8     = av;
    b8     = bv;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // Edges until done8 is seen after the accepting edge; -1 on timeout.
  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    if (!done8) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b0; start13 = 1'b0;
    tick(); tick();
    tests++;
    if ({busy8, done8, diff8, bor8, zero8} !== 12'h000) begin
      fails++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bor=%b zero=%b, want all 0",
               busy8, done8, diff8, bor8, zero8);
    end
    tests++;
    if ({busy13, done13, diff13, bor13, zero13} !== 17'h0) begin
      fails++;
      $display("FAIL reset13: got busy=%b done=%b diff=%h bor=%b zero=%b, want all 0",
               busy13, done13, diff13, bor13, zero13);
    end
    rst = 1'b0;
    tick();
    tests++;
    if (busy8 !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: busy=%b, want 0", busy8);
    end
  endtask

  // Scenario 1: timing of busy/done and a basic result.
  task automatic test_basic();
    int busy_cnt, done_at, done_cnt;
    start_op8(8'h5A, 8'h3C);
    busy_cnt = busy8 ? 1 : 0;
    done_at  = -1;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (busy8) busy_cnt++;
      if (done8) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          tests++;
          if ({diff8, bor8, zero8} !== {8'h1E, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL basic_result: got diff=%h bor=%b zero=%b, want 1e 0 0",
                     diff8, bor8, zero8);
          end
        end
      end
    end
    tests++;
    if (busy_cnt !== 9) begin
      fails++;
      $display("FAIL basic_busy_cycles: got %0d, want 9", busy_cnt);
    end
    tests++;
    if (done_at !== 8) begin
      fails++;
      $display("FAIL basic_done_latency: done seen %0d edges after accept, want 8", done_at);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL basic_done_pulses: got %0d, want 1", done_cnt);
    end
  endtask

  // Scenario 2: borrow cases including 0-1 wrap.
  task automatic test_borrow();
    int n;
    start_op8(8'h3C, 8'h5A);
    wait_done8(n);
    tests++;
    if ({diff8, bor8, zero8} !== {8'hE2, 1'b1, 1'b0} || n !== 8) begin
      fails++;
      $display("FAIL borrow_3c_5a: got diff=%h bor=%b zero=%b lat=%0d, want e2 1 0 lat 8",
               diff8, bor8, zero8, n);
    end
    start_op8(8'h00, 8'h01);
    wait_done8(n);
    tests++;
    if ({diff8, bor8, zero8} !== {8'hFF, 1'b1, 1'b0} || n !== 8) begin
      fails++;
      $display("FAIL borrow_wrap: got diff=%h bor=%b zero=%b lat=%0d, want ff 1 0 lat 8",
               diff8, bor8, zero8, n);
    end
  endtask

  // Scenario 3: zero flag and MSB-only result.
  task automatic test_zero();
    int n;
    start_op8(8'hFF, 8'hFF);
    wait_done8(n);
    tests++;
    if ({diff8, bor8, zero8} !== {8'h00, 1'b0, 1'b1} || n !== 8) begin
      fails++;
      $display("FAIL zero_ff_ff: got diff=%h bor=%b zero=%b lat=%0d, want 00 0 1 lat 8",
               diff8, bor8, zero8, n);
    end
    start_op8(8'h80, 8'h00);
    wait_done8(n);
    tests++;
    if ({diff8, bor8, zero8} !== {8'h80, 1'b0, 1'b0} || n !== 8) begin
      fails++;
      $display("FAIL msb_only: got diff=%h bor=%b zero=%b lat=%0d, want 80 0 0 lat 8",
               diff8, bor8, zero8, n);
    end
  endtask

  // Scenario 4: start held high, operands change mid-run.
  task automatic test_back_to_back();
    int k, done_cnt;
    k = 0;
    while (busy8 && k < 50) begin tick(); k++; end
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    tick();                       // E0: capture 0x10/0x01
    a8 = 8'h77; b8 = 8'h22;
    done_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done8) done_cnt++;
      if (i == 8) begin
        tests++;
        if ({done8, diff8, bor8} !== {1'b1, 8'h0F, 1'b0}) begin
          fails++;
          $display("FAIL b2b_first: got done=%b diff=%h bor=%b, want 1 0f 0", done8, diff8, bor8);
        end
      end
      if (i == 9) begin
        tests++;
        if ({busy8, done8} !== 2'b00) begin
          fails++;
          $display("FAIL b2b_idle_gap: got busy=%b done=%b, want 0 0", busy8, done8);
        end
      end
      if (i == 10) begin
        tests++;
        if (busy8 !== 1'b1) begin
          fails++;
          $display("FAIL b2b_recapture: busy=%b after E10, want 1", busy8);
        end
      end
      if (i == 18) begin
        tests++;
        if ({done8, diff8, bor8} !== {1'b1, 8'h55, 1'b0}) begin
          fails++;
          $display("FAIL b2b_second: got done=%b diff=%h bor=%b, want 1 55 0", done8, diff8, bor8);
        end
      end
    end
    start8 = 1'b0;
    tests++;
    if (done_cnt !== 2) begin
      fails++;
      $display("FAIL b2b_pulse_count: got %0d, want 2", done_cnt);
    end
  endtask

  // Scenario 5: reset mid-run aborts without done, then a clean operation.
  task automatic test_reset_abort();
    int n, done_cnt;
    start_op8(8'h12, 8'h34);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy8, done8, diff8, bor8, zero8} !== 12'h000) begin
      fails++;
      $display("FAIL abort_outputs: got busy=%b done=%b diff=%h bor=%b zero=%b, want all 0",
               busy8, done8, diff8, bor8, zero8);
    end
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) done_cnt++;
    end
    tests++;
    if (done_cnt !== 0) begin
      fails++;
      $display("FAIL abort_quiet: %0d cycles with busy/done after abort, want 0", done_cnt);
    end
    start_op8(8'h34, 8'h12);
    wait_done8(n);
    tests++;
    if ({diff8, bor8, zero8} !== {8'h22, 1'b0, 1'b0} || n !== 8) begin
      fails++;
      $display("FAIL abort_recover: got diff=%h bor=%b zero=%b lat=%0d, want 22 0 0 lat 8",
               diff8, bor8, zero8, n);
    end
  endtask

  // Scenario 6: random traffic. The model tracks only "edges since the
  // accepted start" and computes the result with plain arithmetic.
  task automatic test_random(input int w, input int n_ops);
    int          accepted, dones, since, cyc;
    logic [31:0] mask, ra, rb, ca, cb, e_diff, o_diff;
    logic        s, e_bor, e_zero, o_busy, o_done, o_bor, o_zero;
    mask = (32'd1 << w) - 32'd1;
    accepted = 0; dones = 0; since = -1; cyc = 0;
    ca = '0; cb = '0;
    e_diff = '0; e_bor = 1'b0; e_zero = 1'b0;
    start8 = 1'b0; start13 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    while ((accepted < n_ops || since >= 0) && cyc < 60000) begin
      ra = $urandom & mask;
      rb = $urandom & mask;
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: ra = '0;
        2: rb = mask;
        3: ra = mask;
        default: ;
      endcase
      s   = (accepted < n_ops) && ($urandom_range(0, 3) != 0);
      a8  = ra[7:0];  b8  = rb[7:0];
      a13 = ra[12:0]; b13 = rb[12:0];
      if (w == 8) start8 = s; else start13 = s;
      @(posedge clk);
      if (since < 0) begin
        if (s) begin
          ca = ra; cb = rb; since = 0; accepted++;
        end
      end else begin
        since++;
        if (since == w) begin
          e_diff = (ca - cb) & mask;
          e_bor  = (ca < cb);
          e_zero = (e_diff == 32'd0);
        end else if (since == w + 1) begin
          since = -1;
        end
      end
      #1;
      if (w == 8) begin
        o_busy = busy8;  o_done = done8;  o_diff = {24'd0, diff8};  o_bor = bor8;  o_zero = zero8;
      end else begin
        o_busy = busy13; o_done = done13; o_diff = {19'd0, diff13}; o_bor = bor13; o_zero = zero13;
      end
      if (o_done) dones++;
      tests++;
      if ({o_busy, o_done, o_diff, o_bor, o_zero} !==
          {(since >= 0), (since == w), e_diff, e_bor, e_zero}) begin
        fails++;
        $display("FAIL rand_w%0d cyc %0d: got busy=%b done=%b diff=%h bor=%b zero=%b, want busy=%b done=%b diff=%h bor=%b zero=%b",
                 w, cyc, o_busy, o_done, o_diff, o_bor, o_zero,
                 (since >= 0), (since == w), e_diff, e_bor, e_zero);
      end
      cyc++;
    end
    start8 = 1'b0; start13 = 1'b0;
    tests++;
    if (accepted !== n_ops || since >= 0) begin
      fails++;
      $display("FAIL rand_w%0d_budget: accepted %0d of %0d ops before cycle limit", w, accepted, n_ops);
    end
    tests++;
    if (dones !== accepted) begin
      fails++;
      $display("FAIL rand_w%0d_done_count: got %0d done pulses, want %0d", w, dones, accepted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_zero();
    test_back_to_back();
    test_reset_abort();
    test_random(8, 1000);
    test_random(13, 1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit unsigned subtractor controller. It sequences a single-bit subtract stage: a full subtractor built from two half-subtractor cells plus a borrow flip-flop. Each cycle it feeds that stage one operand bit pair, LSB first. It captures operands on a start handshake, runs WIDTH bit-cycles, then presents a registered difference, final borrow and zero flag with a one-cycle done pulse. It is the area-minimal alternative to a ripple subtractor for the arithmetic datapath.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request to begin a subtraction; sampled only in IDLE.
a  input  WIDTH  minuend; captured on the accepted start edge.
b  input  WIDTH  subtrahend; captured on the accepted start edge.
busy  output  1  high in RUN and DONE states.
done  output  1  one-cycle pulse when result outputs update.
diff  output  WIDTH  registered a-b mod 2^WIDTH; holds until the next done.
borrow_out  output  1  final borrow; 1 iff a<b unsigned; holds with diff.
zero  output  1  registered (diff==0); holds with diff.

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - busy, done, diff, borrow_out, zero all 0.
  - Internal operand shift registers, result shift register, borrow FF and bit counter cleared.
  - Reset overrides every other input and aborts an in-progress operation with no done pulse.
- States: IDLE, RUN, DONE; encoding is free.
- IDLE:
  - On an edge with start=1: load a and b into shift registers, clear borrow FF, set bit counter=0, go to RUN.
  - start=0: remain in IDLE.
- RUN, one bit per edge:
  - a0, b0 are the current LSBs; bin is the borrow FF.
  - d = a0^b0^bin.
  - bout = (~a0&b0) | (~(a0^b0)&bin).
  - d is shifted into the result register MSB; the result register shifts right.
  - Operand registers shift right; borrow FF <= bout; counter increments.
  - On the edge that processes bit WIDTH-1 (counter==WIDTH-1): go to DONE, and in the same edge load diff with the completed result, borrow_out with that bit's bout, and zero with (completed result==0).
- DONE:
  - done=1 for exactly this one cycle.
  - Next edge returns to IDLE; done returns to 0.
- Latency:
  - start accepted at edge E0.
  - RUN occupies edges E1..EWIDTH.
  - done is high during the cycle after EWIDTH.
  - The earliest next start is accepted at edge EWIDTH+2, i.e. one result every WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored: no restart, no operand recapture. Changes on a/b after capture have no effect.
- busy=0 only in IDLE. done and busy are both Moore outputs (decoded from state or registered), never combinational from start.
- diff, borrow_out and zero change only on the DONE-entry edge or on reset.
- Arithmetic:
  - Purely unsigned modulo 2^WIDTH; no saturation.
  - Borrow wraps naturally, e.g. 0-1 = all-ones with borrow_out=1.
- Counter width is $clog2(WIDTH) bits, wide enough for WIDTH-1 with no wrap ambiguity.

Test Plan:
1. WIDTH=8, reset 2 cycles then a=0x5A, b=0x3C, start 1 cycle -> busy high 9 cycles, done pulse exactly 9 cycles after start edge; diff=0x1E, borrow_out=0, zero=0.
2. a=0x3C, b=0x5A -> diff=0xE2, borrow_out=1, zero=0. Then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
3. a=0xFF, b=0xFF -> diff=0x00, borrow_out=0, zero=1. Then a=0x80, b=0x00 -> diff=0x80, borrow_out=0, zero=0.
4. Start held continuously high with a=0x10, b=0x01, and operands changed to 0x77/0x22 during RUN -> results 0x0F/0 produced; the second capture occurs exactly at edge E10 (next IDLE cycle) and uses the current a/b; a pulse every 10 cycles, no mid-run restart.
5. Assert rst at RUN bit 4 of a=0x12, b=0x34 -> next cycle all outputs 0, state IDLE, no done. A new start with a=0x34, b=0x12 -> diff=0x22, borrow_out=0.
6. Randomized 1000 ops, WIDTH=8 and WIDTH=13, checked against a reference model a-b -> diff, borrow_out and zero match every time; done count equals accepted-start count.
